edram_block_ecc_stream: RTL and testbench

//  Streaming, parametrised 2-D parity ECC engine for eDRAM blocks. One block is ROWS rows x COLS bits,

---
 rtl/edram_block_ecc_stream.sv | 188 ++++++++++++++++++
 tb/tb_edram_block_ecc_stream.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/edram_block_ecc_stream.sv
// Streaming 2-D parity ECC engine: accumulates row/column/diagonal parity over a ROWS x COLS block,
// classifies decode syndromes, and replays the (corrected) block from a one-block buffer.
module edram_block_ecc_stream #(
   parameter int ROWS = 19,
   parameter int COLS = 18,
   parameter int RW   = $clog2(ROWS),
   parameter int CW   = $clog2(COLS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mode,
   input  logic            in_vld,
   output logic            in_rdy,
   input  logic [COLS-1:0] in_data,
   input  logic [ROWS-1:0] chk_row_in,
   input  logic [COLS-1:0] chk_col_in,
   input  logic [COLS-1:0] chk_dia_in,
   output logic            out_vld,
   input  logic            out_rdy,
   output logic [COLS-1:0] out_data,
   output logic            out_last,
   output logic [ROWS-1:0] chk_row,
   output logic [COLS-1:0] chk_col,
   output logic [COLS-1:0] chk_dia,
   output logic            st_vld,
   output logic            st_corr,
   output logic            st_chk,
   output logic            st_unc,
   output logic [RW-1:0]   err_row,
   output logic [CW-1:0]   err_col
);

   typedef enum logic [1:0] {IDLE, ACC, SYND, DRN} state_t;

   state_t          state, state_nxt;
   logic [COLS-1:0] mem [ROWS];
   logic [RW-1:0]   rcnt, ocnt, row_idx;
   logic [ROWS-1:0] prow, chk_row_l, chk_row_q, sr;
   logic [COLS-1:0] pcol, pdia, chk_col_l, chk_dia_l, chk_col_q, chk_dia_q;
   logic [COLS-1:0] sc, sd, dia_row, dia_oh, flip;
   logic            mode_q, accept, row_last, drain_xfer;
   logic            corr_c, chkerr_c, unc_c, corr_q, chkerr_q, unc_q;
   logic            one_r, one_c, one_d, zero_r, zero_c, zero_d;
   logic [RW-1:0]   r_hit, err_row_q;
   logic [CW-1:0]   c_hit, err_col_q;

   assign in_rdy     = (state == IDLE) || (state == ACC);
   assign accept     = in_vld && in_rdy;
   assign row_idx    = (state == IDLE) ? '0 : rcnt;
   assign row_last   = accept && (state == ACC) && (rcnt == RW'(ROWS - 1));
   assign out_vld    = (state == DRN);
   assign out_last   = out_vld && (ocnt == RW'(ROWS - 1));
   assign drain_xfer = out_vld && out_rdy;
   assign st_vld     = (state == SYND);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ACC;
         ACC:     if (row_last) state_nxt = SYND;
         SYND:    state_nxt = DRN;
         DRN:     if (drain_xfer && out_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Diagonal contribution of the incoming row: bit c lands on diagonal (r+c) mod COLS.
   always_comb begin
      dia_row = '0;
      for (int d = 0; d < COLS; d++) begin
         for (int c = 0; c < COLS; c++) begin
            if (((int'(row_idx) + c) % COLS) == d) dia_row[d] = dia_row[d] ^ in_data[c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[row_idx] <= in_data;
   end

   // Row 0 restarts the accumulators and captures mode and stored check bits for the whole block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt      <= '0;
         prow      <= '0;
         pcol      <= '0;
         pdia      <= '0;
         mode_q    <= 1'b0;
         chk_row_l <= '0;
         chk_col_l <= '0;
         chk_dia_l <= '0;
      end else if (accept) begin
         if (state == IDLE) begin
            prow      <= ROWS'(^in_data);
            pcol      <= in_data;
            pdia      <= dia_row;
            mode_q    <= mode;
            chk_row_l <= chk_row_in;
            chk_col_l <= chk_col_in;
            chk_dia_l <= chk_dia_in;
            rcnt      <= RW'(1);
         end else begin
            prow[rcnt] <= ^in_data;
            pcol       <= pcol ^ in_data;
            pdia       <= pdia ^ dia_row;
            rcnt       <= row_last ? '0 : rcnt + RW'(1);
         end
      end
   end

   always_comb begin
      sr     = prow ^ chk_row_l;
      sc     = pcol ^ chk_col_l;
      sd     = pdia ^ chk_dia_l;
      zero_r = (sr == '0);
      zero_c = (sc == '0);
      zero_d = (sd == '0);
      one_r  = ($countones(sr) == 1);
      one_c  = ($countones(sc) == 1);
      one_d  = ($countones(sd) == 1);
      r_hit  = '0;
      c_hit  = '0;
      for (int i = 0; i < ROWS; i++) if (sr[i]) r_hit = RW'(i);
      for (int i = 0; i < COLS; i++) if (sc[i]) c_hit = CW'(i);
      dia_oh = '0;
      for (int d = 0; d < COLS; d++) begin
         if (((int'(r_hit) + int'(c_hit)) % COLS) == d) dia_oh[d] = 1'b1;
      end
      corr_c   = 1'b0;
      chkerr_c = 1'b0;
      unc_c    = 1'b0;
      if (mode_q && !(zero_r && zero_c && zero_d)) begin
         if (one_r && one_c && one_d && (sd == dia_oh))
            corr_c = 1'b1;
         else if ((one_r && zero_c && zero_d) || (zero_r && one_c && zero_d) ||
                  (zero_r && zero_c && one_d))
            chkerr_c = 1'b1;
         else
            unc_c = 1'b1;
      end
   end

   // Status and check bits are shown live during SYND, then held until the next SYND.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_row_q <= '0;
         chk_col_q <= '0;
         chk_dia_q <= '0;
         corr_q    <= 1'b0;
         chkerr_q  <= 1'b0;
         unc_q     <= 1'b0;
         err_row_q <= '0;
         err_col_q <= '0;
      end else if (state == SYND) begin
         chk_row_q <= prow;
         chk_col_q <= pcol;
         chk_dia_q <= pdia;
         corr_q    <= corr_c;
         chkerr_q  <= chkerr_c;
         unc_q     <= unc_c;
         err_row_q <= corr_c ? r_hit : '0;
         err_col_q <= corr_c ? c_hit : '0;
      end
   end

   assign chk_row = st_vld ? prow : chk_row_q;
   assign chk_col = st_vld ? pcol : chk_col_q;
   assign chk_dia = st_vld ? pdia : chk_dia_q;
   assign st_corr = st_vld ? corr_c : corr_q;
   assign st_chk  = st_vld ? chkerr_c : chkerr_q;
   assign st_unc  = st_vld ? unc_c : unc_q;
   assign err_row = st_vld ? (corr_c ? r_hit : '0) : err_row_q;
   assign err_col = st_vld ? (corr_c ? c_hit : '0) : err_col_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             ocnt <= '0;
      else if (drain_xfer) ocnt <= out_last ? '0 : ocnt + RW'(1);
   end

   assign flip     = COLS'(1) << err_col_q;
   assign out_data = mem[ocnt] ^ ((corr_q && (ocnt == err_row_q)) ? flip : '0);

endmodule

// File: tb/tb_edram_block_ecc_stream.sv
// Self-checking bench for edram_block_ecc_stream: table of block scenarios, scoreboard of replayed rows,
// plus a hand-written mid-block reset sequence.
module tb_edram_block_ecc_stream;

   localparam int ROWS = 19;
   localparam int COLS = 18;
   localparam int RW   = 5;
   localparam int CW   = 5;

   logic            clk, rst, mode, in_vld, in_rdy, out_vld, out_rdy, out_last;
   logic [COLS-1:0] in_data, chk_col_in, chk_dia_in, out_data, chk_col, chk_dia;
   logic [ROWS-1:0] chk_row_in, chk_row;
   logic            st_vld, st_corr, st_chk, st_unc;
   logic [RW-1:0]   err_row;
   logic [CW-1:0]   err_col;

   edram_block_ecc_stream dut (
      .clk(clk), .rst(rst), .mode(mode), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
      .chk_row_in(chk_row_in), .chk_col_in(chk_col_in), .chk_dia_in(chk_dia_in),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
      .chk_row(chk_row), .chk_col(chk_col), .chk_dia(chk_dia), .st_vld(st_vld),
      .st_corr(st_corr), .st_chk(st_chk), .st_unc(st_unc), .err_row(err_row), .err_col(err_col)
   );

   typedef struct {
      logic mode;
      int   nflip;
      int   fr0, fc0, fr1, fc1;
      int   cgrp;
      int   cbit;
      bit   rnd;
      bit   toggle;
      logic ex_corr, ex_chk, ex_unc;
      int   ex_er, ex_ec;
   } vec_t;

   typedef struct {
      logic [COLS-1:0] data;
      logic            last;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[9];

   logic [COLS-1:0] base_rows [ROWS];
   logic [COLS-1:0] fed_rows  [ROWS];
   logic            hold_pending = 1'b0;
   logic [COLS-1:0] hold_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic calcParity(input logic [COLS-1:0] rows [ROWS], output logic [ROWS-1:0] pr,
                             output logic [COLS-1:0] pc, output logic [COLS-1:0] pd);
      pr = '0;
      pc = '0;
      pd = '0;
      for (int r = 0; r < ROWS; r++) begin
         pc = pc ^ rows[r];
         for (int c = 0; c < COLS; c++) begin
            pr[r] = pr[r] ^ rows[r][c];
            pd[(r + c) % COLS] = pd[(r + c) % COLS] ^ rows[r][c];
         end
      end
   endtask

   // Drives one row; mode and check inputs are scrambled after row 0 since the DUT must ignore them.
   task automatic applyStimulus(input int r, input logic m, input logic [COLS-1:0] d,
                                input logic [ROWS-1:0] cr, input logic [COLS-1:0] cc,
                                input logic [COLS-1:0] cd);
      checkOutput("in_rdy_acc", in_rdy, 1);
      in_vld     = 1'b1;
      in_data    = d;
      mode       = (r == 0) ? m : ~m;
      chk_row_in = (r == 0) ? cr : ~cr;
      chk_col_in = (r == 0) ? cc : ~cc;
      chk_dia_in = (r == 0) ? cd : ~cd;
      @(posedge clk);
      #1;
      in_vld = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            checkOutput("hold_vld", out_vld, 1);
            checkOutput("hold_data", out_data, hold_data);
         end
         if (out_vld && out_rdy) begin
            if (sbq.size() == 0) begin
               checkOutput("extra_row", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               checkOutput("out_data", out_data, e.data);
               checkOutput("out_last", out_last, e.last);
            end
         end
         hold_pending = out_vld && !out_rdy;
         hold_data    = out_data;
      end
   end

   task automatic runBlock(input vec_t v);
      logic [ROWS-1:0] er, xr;
      logic [COLS-1:0] ec, ed, xc, xd;
      bit              done;
      exp_t            e;
      for (int r = 0; r < ROWS; r++) begin
         base_rows[r] = v.rnd ? COLS'($urandom) : '0;
         fed_rows[r]  = base_rows[r];
      end
      if (v.nflip >= 1) fed_rows[v.fr0][v.fc0] = ~fed_rows[v.fr0][v.fc0];
      if (v.nflip >= 2) fed_rows[v.fr1][v.fc1] = ~fed_rows[v.fr1][v.fc1];
      calcParity(base_rows, er, ec, ed);
      calcParity(fed_rows, xr, xc, xd);
      if (v.mode == 1'b0) begin
         er = ROWS'($urandom);
         ec = COLS'($urandom);
         ed = COLS'($urandom);
      end else if (v.cgrp == 0) er[v.cbit] = ~er[v.cbit];
      else if (v.cgrp == 1) ec[v.cbit] = ~ec[v.cbit];
      else if (v.cgrp == 2) ed[v.cbit] = ~ed[v.cbit];
      for (int r = 0; r < ROWS; r++) begin
         e.data = v.ex_corr ? base_rows[r] : fed_rows[r];
         e.last = (r == ROWS - 1);
         sbq.push_back(e);
      end
      out_rdy = 1'b1;
      for (int r = 0; r < ROWS; r++) applyStimulus(r, v.mode, fed_rows[r], er, ec, ed);
      @(negedge clk);
      checkOutput("st_vld_synd", st_vld, 1);
      checkOutput("out_vld_synd", out_vld, 0);
      checkOutput("in_rdy_synd", in_rdy, 0);
      checkOutput("flags_synd", {st_corr, st_chk, st_unc}, {v.ex_corr, v.ex_chk, v.ex_unc});
      if (v.ex_corr) begin
         checkOutput("err_row", err_row, v.ex_er);
         checkOutput("err_col", err_col, v.ex_ec);
      end
      checkOutput("chk_row", chk_row, xr);
      checkOutput("chk_col", chk_col, xc);
      checkOutput("chk_dia", chk_dia, xd);
      @(negedge clk);
      checkOutput("latency_out_vld", out_vld, 1);
      checkOutput("st_vld_pulse", st_vld, 0);
      done = 1'b0;
      for (int cyc = 0; cyc < 6 * ROWS && !done; cyc++) begin
         @(posedge clk);
         #1;
         if (v.toggle) out_rdy = ~out_rdy;
         @(negedge clk);
         if (!out_vld) done = 1'b1;
         else checkOutput("in_rdy_drn", in_rdy, 0);
      end
      checkOutput("drain_done", done, 1);
      checkOutput("sb_empty", sbq.size(), 0);
      checkOutput("in_rdy_idle", in_rdy, 1);
      checkOutput("flags_held", {st_corr, st_chk, st_unc}, {v.ex_corr, v.ex_chk, v.ex_unc});
      checkOutput("chk_col_held", chk_col, xc);
      out_rdy = 1'b1;
      sbq.delete();
   endtask

   initial begin
      //          mode  nf fr0 fc0 fr1 fc1 grp bit rnd  tog  corr  chk   unc   er  ec
      vecs[0] = '{1'b0, 0, 0,  0,  0,  0,  -1, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0};
      vecs[1] = '{1'b1, 1, 5,  7,  0,  0,  -1, 0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5,  7};
      vecs[2] = '{1'b1, 0, 0,  0,  0,  0,  1,  3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0,  0};
      vecs[3] = '{1'b1, 2, 2,  4,  9,  11, -1, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0};
      vecs[4] = '{1'b1, 0, 0,  0,  0,  0,  -1, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0};
      vecs[5] = '{1'b0, 0, 0,  0,  0,  0,  -1, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  0};
      vecs[6] = '{1'b1, 0, 0,  0,  0,  0,  0,  0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0,  0};
      vecs[7] = '{1'b1, 1, 18, 17, 0,  0,  -1, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18, 17};
      vecs[8] = '{1'b1, 0, 0,  0,  0,  0,  2,  17, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0,  0};

      rst        = 1'b1;
      mode       = 1'b0;
      in_vld     = 1'b0;
      in_data    = '0;
      chk_row_in = '0;
      chk_col_in = '0;
      chk_dia_in = '0;
      out_rdy    = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_in_rdy", in_rdy, 1);
      checkOutput("rst_out_vld", out_vld, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_st", {st_vld, st_corr, st_chk, st_unc}, 0);
      checkOutput("rst_chk", {chk_row, chk_col, chk_dia}, 0);
      checkOutput("rst_err", {err_row, err_col}, 0);
      rst = 1'b0;

      runBlock(vecs[0]);
      runBlock(vecs[1]);

      // Abort a decode block after row 10; the following block must be unaffected.
      for (int r = 0; r < ROWS; r++) fed_rows[r] = COLS'($urandom);
      for (int r = 0; r <= 10; r++) applyStimulus(r, 1'b1, fed_rows[r], '1, '1, '1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_in_rdy", in_rdy, 1);
      checkOutput("abort_out_vld", out_vld, 0);
      checkOutput("abort_flags", {st_vld, st_corr, err_row}, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_idle_out_vld", out_vld, 0);

      for (int i = 1; i < 9; i++) runBlock(vecs[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
